// File: rtl/axi_pkg.sv
// Shared AXI read-path widths and packet layouts, used by the read arbiter
// and by the CDC wrapper that carries these packets across clock domains.
package axi_pkg;

    localparam int ID_M_W   = 4;
    localparam int ID_S_W   = 8;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int AR_PKT_W = 49;
    localparam int R_PKT_W  = 43;

    typedef struct packed {
        logic [ID_S_W-1:0] id;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ar_pkt_t;

    typedef struct packed {
        logic [ID_S_W-1:0] id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_pkt_t;

    // Beat as presented to a master: the tag is stripped back to its own ID.
    typedef struct packed {
        logic [ID_M_W-1:0] id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } rd_beat_t;

    // Master index sits just above the master's own ID bits.
    function automatic logic [ID_S_W-1:0] tag_id(input logic midx, input logic [ID_M_W-1:0] id);
        return {3'b000, midx, id};
    endfunction

endpackage

// File: rtl/rd_out_reg.sv
// One-entry R output register for a single master; contents are held
// stable while valid and not accepted.
module rd_out_reg
    import axi_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  rd_beat_t din,
    input  logic     rready,
    output logic     rvalid,
    output rd_beat_t dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            dout   <= '0;
        end else if (load) begin
            rvalid <= 1'b1;
            dout   <= din;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter in front of a shared AR/R CDC: round-robin
// AR grant with ID tagging, R beats routed back by tag through output regs.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_M_W-1:0]   ARID_M0,
    input  logic [ADDR_W-1:0]   ARADDR_M0,
    input  logic [3:0]          ARLEN_M0,
    input  logic [2:0]          ARSIZE_M0,
    input  logic [1:0]          ARBURST_M0,
    input  logic                ARVALID_M0,
    output logic                ARREADY_M0,
    input  logic [ID_M_W-1:0]   ARID_M1,
    input  logic [ADDR_W-1:0]   ARADDR_M1,
    input  logic [3:0]          ARLEN_M1,
    input  logic [2:0]          ARSIZE_M1,
    input  logic [1:0]          ARBURST_M1,
    input  logic                ARVALID_M1,
    output logic                ARREADY_M1,
    output logic [ID_M_W-1:0]   RID_M0,
    output logic [DATA_W-1:0]   RDATA_M0,
    output logic [1:0]          RRESP_M0,
    output logic                RLAST_M0,
    output logic                RVALID_M0,
    input  logic                RREADY_M0,
    output logic [ID_M_W-1:0]   RID_M1,
    output logic [DATA_W-1:0]   RDATA_M1,
    output logic [1:0]          RRESP_M1,
    output logic                RLAST_M1,
    output logic                RVALID_M1,
    input  logic                RREADY_M1,
    input  logic                AR_not_full,
    output logic                AR_wr_en,
    output logic [AR_PKT_W-1:0] AR_w_data,
    input  logic                R_not_empty,
    input  logic [R_PKT_W-1:0]  R_r_data,
    output logic                R_rd_en
);

    localparam int NUM_M = 2;

    logic [NUM_M-1:0]            arvalid, elig, grant, ar_hs;
    logic [NUM_M-1:0]            rready, rvalid, load, last_hs;
    logic [NUM_M-1:0][CNT_W-1:0] cnt_q;
    ar_pkt_t [NUM_M-1:0]         ar_req;
    rd_beat_t [NUM_M-1:0]        beat_q;
    logic                        rr_ptr_q;
    r_pkt_t                      r_head;
    rd_beat_t                    r_beat;
    logic                        dst;
    logic                        unused_tag_bits;

    assign arvalid = {ARVALID_M1, ARVALID_M0};
    assign rready  = {RREADY_M1, RREADY_M0};

    assign ar_req[0] = '{id: tag_id(1'b0, ARID_M0), addr: ARADDR_M0, len: ARLEN_M0,
                         size: ARSIZE_M0, burst: ARBURST_M0};
    assign ar_req[1] = '{id: tag_id(1'b1, ARID_M1), addr: ARADDR_M1, len: ARLEN_M1,
                         size: ARSIZE_M1, burst: ARBURST_M1};

    always_comb begin
        grant = elig;
        if (&elig) begin
            grant           = '0;
            grant[rr_ptr_q] = 1'b1;
        end
    end

    assign ar_hs      = grant & {NUM_M{AR_not_full & ~rst}};
    assign AR_wr_en   = |ar_hs;
    assign AR_w_data  = grant[1] ? ar_req[1] : ar_req[0];
    assign ARREADY_M0 = ar_hs[0];
    assign ARREADY_M1 = ar_hs[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr_q <= 1'b0;
        else if (ar_hs[0])
            rr_ptr_q <= 1'b1;
        else if (ar_hs[1])
            rr_ptr_q <= 1'b0;
    end

    // The owning master index is tag bit 4; the upper tag bits carry no routing.
    assign r_head          = r_pkt_t'(R_r_data);
    assign dst             = r_head.id[4];
    assign unused_tag_bits = ^r_head.id[7:5];
    assign r_beat          = '{id: r_head.id[ID_M_W-1:0], data: r_head.data,
                               resp: r_head.resp, last: r_head.last};
    assign R_rd_en         = R_not_empty & ~rst & (~rvalid[dst] | rready[dst]);

    for (genvar g = 0; g < NUM_M; g++) begin : g_mst
        assign elig[g]    = arvalid[g] & (cnt_q[g] < CNT_W'(MAX_OUT));
        assign load[g]    = R_rd_en & (dst == 1'(g));
        assign last_hs[g] = rvalid[g] & rready[g] & beat_q[g].last;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q[g] <= '0;
            end else begin
                case ({ar_hs[g], last_hs[g]})
                    2'b10:   cnt_q[g] <= cnt_q[g] + CNT_W'(1);
                    2'b01:   if (cnt_q[g] != '0) cnt_q[g] <= cnt_q[g] - CNT_W'(1);
                    default: cnt_q[g] <= cnt_q[g];
                endcase
            end
        end

        rd_cnt_underflow: assert property (@(posedge clk) disable iff (rst)
            last_hs[g] |-> (cnt_q[g] != '0));

        rd_out_reg u_out (
            .clk    (clk),
            .rst    (rst),
            .load   (load[g]),
            .din    (r_beat),
            .rready (rready[g]),
            .rvalid (rvalid[g]),
            .dout   (beat_q[g])
        );
    end

    assign RVALID_M0 = rvalid[0];
    assign RID_M0    = beat_q[0].id;
    assign RDATA_M0  = beat_q[0].data;
    assign RRESP_M0  = beat_q[0].resp;
    assign RLAST_M0  = beat_q[0].last;
    assign RVALID_M1 = rvalid[1];
    assign RID_M1    = beat_q[1].id;
    assign RDATA_M1  = beat_q[1].data;
    assign RRESP_M1  = beat_q[1].resp;
    assign RLAST_M1  = beat_q[1].last;

endmodule
